// File: rtl/nand_loader.sv
// Host-side load/run/dump controller for nand_cpu: byte-stream commands in,
// byte writes to I_MEM/D_MEM, CPU reset control and a D_MEM dump stream out.
module nand_loader #(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [7:0]         mem_wdata,
  input  logic [7:0]         dmem_rdata,
  output logic               cpu_n_rst,
  input  logic               cpu_halt,
  output logic               busy,
  output logic               err
);

  localparam logic [7:0] CMD_LOAD_I = 8'h01;
  localparam logic [7:0] CMD_LOAD_D = 8'h02;
  localparam logic [7:0] CMD_RUN    = 8'h03;
  localparam logic [7:0] CMD_DUMP_D = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_RUN,
    S_DRD,
    S_DOUT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  cmd;
  logic [1:0]  hdr_cnt;
  logic [15:0] addr;
  logic [15:0] len;
  logic [15:0] addr_inc;
  logic [15:0] len_hdr;
  logic        accept;
  logic        is_load;

  // in_ready is gated by n_rst so it reads 0 for the whole reset window
  assign in_ready  = n_rst && (state == S_IDLE || state == S_HDR || state == S_DATA);
  assign out_valid = (state == S_DOUT);
  assign busy      = (state != S_IDLE);
  assign accept    = in_valid && in_ready;
  assign addr_inc  = addr + 16'd1;
  assign len_hdr   = {in_data, len[7:0]};
  assign is_load   = (in_data == CMD_LOAD_I) || (in_data == CMD_LOAD_D);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_load || in_data == CMD_DUMP_D) begin
            state_next = S_HDR;
          end else if (in_data == CMD_RUN) begin
            state_next = S_RUN;
          end
        end
      end
      S_HDR: begin
        if (accept && hdr_cnt == 2'd3) begin
          if (len_hdr == 16'd0) begin
            state_next = S_IDLE;
          end else if (cmd == CMD_DUMP_D) begin
            state_next = S_DRD;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept && len == 16'd1) begin
          state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (cpu_halt) begin
          state_next = S_IDLE;
        end
      end
      S_DRD: begin
        state_next = S_DOUT;
      end
      S_DOUT: begin
        if (out_ready) begin
          state_next = (len == 16'd1) ? S_IDLE : S_DRD;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Write strobes are single-cycle pulses registered one cycle after the byte is taken
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cmd       <= 8'h00;
      hdr_cnt   <= 2'd0;
      addr      <= 16'h0000;
      len       <= 16'h0000;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      dmem_we   <= 1'b0;
      dmem_addr <= '0;
      mem_wdata <= 8'h00;
      out_data  <= 8'h00;
      cpu_n_rst <= 1'b0;
      err       <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cmd     <= in_data;
            hdr_cnt <= 2'd0;
            if (is_load) begin
              cpu_n_rst <= 1'b0;
            end else if (in_data == CMD_RUN) begin
              cpu_n_rst <= 1'b1;
            end else if (in_data != CMD_DUMP_D) begin
              err <= 1'b1;
            end
          end
        end
        S_HDR: begin
          if (accept) begin
            hdr_cnt <= hdr_cnt + 2'd1;
            case (hdr_cnt)
              2'd0:    addr[7:0]  <= in_data;
              2'd1:    addr[15:8] <= in_data;
              2'd2:    len[7:0]   <= in_data;
              default: len[15:8]  <= in_data;
            endcase
            // The address is complete by the last header byte, so a dump can start reading
            if (hdr_cnt == 2'd3) begin
              dmem_addr <= addr[DMEM_AW-1:0];
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            mem_wdata <= in_data;
            if (cmd == CMD_LOAD_I) begin
              imem_we   <= 1'b1;
              imem_addr <= addr[IMEM_AW-1:0];
            end else begin
              dmem_we   <= 1'b1;
              dmem_addr <= addr[DMEM_AW-1:0];
            end
            addr <= addr_inc;
            len  <= len - 16'd1;
          end
        end
        S_DRD: begin
          out_data <= dmem_rdata;
        end
        S_DOUT: begin
          if (out_ready) begin
            addr      <= addr_inc;
            len       <= len - 16'd1;
            dmem_addr <= addr_inc[DMEM_AW-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand_loader.sv
// Self-checking bench for nand_loader: table-driven loads plus hand-written
// run, dump, bad-command and mid-operation reset sequences, with scoreboards.
module tb_nand_loader;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic       dmem_we;
  logic [7:0] dmem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] dmem_rdata;
  logic       cpu_n_rst;
  logic       cpu_halt;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  nand_loader #(.IMEM_AW(8), .DMEM_AW(8)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .mem_wdata(mem_wdata),
    .dmem_rdata(dmem_rdata),
    .cpu_n_rst(cpu_n_rst),
    .cpu_halt(cpu_halt),
    .busy(busy),
    .err(err)
  );

  typedef struct {
    bit         is_d;
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [15:0] len;
    logic [31:0] data;
    logic [31:0] exp_addrs;
    int          exp_i;
    int          exp_d;
  } vec_t;

  wr_t        wq[$];
  logic [7:0] oq[$];
  wr_t        mon_w;
  vec_t       vecs[4];
  logic [7:0] dmem_mem[256];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int n_istb = 0;
  int n_dstb = 0;
  int n_out = 0;

  logic       prev_ov = 1'b0;
  logic       prev_or = 1'b0;
  logic [7:0] prev_od = 8'h00;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_mis++;
    $display("[TB] FAIL %s", name);
  endtask

  // D_MEM model: byte writes on the clock edge, read data settles before the next edge
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (dmem_we === 1'b1) dmem_mem[dmem_addr] <= mem_wdata;
  always @(negedge clk) dmem_rdata <= dmem_mem[dmem_addr];

  always @(negedge clk) begin
    if (imem_we === 1'b1 || dmem_we === 1'b1) begin
      if (imem_we === 1'b1) n_istb++;
      if (dmem_we === 1'b1) n_dstb++;
      check_output("strobe_exclusive", {31'd0, imem_we & dmem_we}, 32'd0);
      if (wq.size() == 0) begin
        fail_now("unexpected_strobe");
      end else begin
        mon_w = wq.pop_front();
        check_output("strobe_target", {31'd0, dmem_we}, {31'd0, mon_w.is_d});
        check_output("strobe_addr", dmem_we ? dmem_addr : imem_addr, mon_w.addr);
        check_output("strobe_data", mem_wdata, mon_w.data);
        check_output("strobe_cycle", cyc, mon_w.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (prev_ov === 1'b1 && prev_or === 1'b0) begin
      check_output("out_hold_valid", {31'd0, out_valid}, 32'd1);
      check_output("out_hold_data", out_data, prev_od);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_out++;
      if (oq.size() == 0) fail_now("unexpected_out_byte");
      else check_output("out_byte", out_data, oq.pop_front());
    end
    prev_ov <= out_valid;
    prev_or <= out_ready;
    prev_od <= out_data;
  end

  // Offer one byte and hold it until the loader takes it; optionally expect a write
  task automatic send_byte(input logic [7:0] b, input bit push, input bit is_d,
                           input logic [7:0] exp_addr);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      fail_now("in_ready_timeout");
      in_valid = 1'b0;
      return;
    end
    if (push) wq.push_back('{is_d, exp_addr, b, cyc + 1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    send_byte(v.cmd, 1'b0, 1'b0, 8'h00);
    send_byte(v.addr[7:0], 1'b0, 1'b0, 8'h00);
    send_byte(v.addr[15:8], 1'b0, 1'b0, 8'h00);
    send_byte(v.len[7:0], 1'b0, 1'b0, 8'h00);
    send_byte(v.len[15:8], 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < int'(v.len); i++) begin
      send_byte(v.data[8*i +: 8], 1'b1, v.cmd == 8'h02, v.exp_addrs[8*i +: 8]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int i0;
    int d0;
    int o0;
    int bad;
    int k;

    vecs[0] = '{8'h02, 16'h0000, 16'd4, 32'hDDCCBBAA, 32'h03020100, 0, 4};
    vecs[1] = '{8'h01, 16'h00FE, 16'd3, 32'h00332211, 32'h0000FFFE, 3, 0};
    vecs[2] = '{8'h01, 16'h0010, 16'd0, 32'h00000000, 32'h00000000, 0, 0};
    vecs[3] = '{8'h02, 16'h1204, 16'd2, 32'h0000C35A, 32'h00000504, 0, 2};

    for (int a = 0; a < 256; a++) dmem_mem[a] = 8'h00;

    n_rst     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h02;
    out_ready = 1'b0;
    cpu_halt  = 1'b0;

    @(posedge clk);
    @(negedge clk);
    check_output("reset_outputs",
                 {24'd0, in_ready, out_valid, cpu_n_rst, imem_we, dmem_we, err, busy, out_data[0]},
                 32'd0);
    @(posedge clk);
    #1;
    n_rst    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_output("release_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("release_busy", {31'd0, busy}, 32'd0);
    check_output("release_cpu_n_rst", {31'd0, cpu_n_rst}, 32'd0);
    @(posedge clk);
    #1;

    for (int r = 0; r < 4; r++) begin
      i0 = n_istb;
      d0 = n_dstb;
      apply_stimulus(vecs[r]);
      @(negedge clk);
      check_output($sformatf("row%0d_busy", r), {31'd0, busy}, 32'd0);
      check_output($sformatf("row%0d_in_ready", r), {31'd0, in_ready}, 32'd1);
      check_output($sformatf("row%0d_cpu_n_rst", r), {31'd0, cpu_n_rst}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check_output($sformatf("row%0d_pending", r), wq.size(), 32'd0);
      check_output($sformatf("row%0d_imem_strobes", r), n_istb - i0, vecs[r].exp_i);
      check_output($sformatf("row%0d_dmem_strobes", r), n_dstb - d0, vecs[r].exp_d);
    end

    // RUN: CPU released, input stream blocked until halt
    send_byte(8'h03, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check_output("run_cpu_n_rst", {31'd0, cpu_n_rst}, 32'd1);
    check_output("run_in_ready", {31'd0, in_ready}, 32'd0);
    bad      = 0;
    in_valid = 1'b1;
    in_data  = 8'h7F;
    repeat (50) begin
      @(negedge clk);
      if (cpu_n_rst !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    check_output("run_hold_bad_cycles", bad, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cpu_halt = 1'b1;
    @(posedge clk);
    #1;
    cpu_halt = 1'b0;
    check_output("halt_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("halt_busy", {31'd0, busy}, 32'd0);
    check_output("halt_cpu_n_rst", {31'd0, cpu_n_rst}, 32'd1);
    check_output("run_ignored_bytes_err", {31'd0, err}, 32'd0);
    send_byte(8'h01, 1'b0, 1'b0, 8'h00);
    check_output("load_rehold_cpu", {31'd0, cpu_n_rst}, 32'd0);
    repeat (4) send_byte(8'h00, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check_output("load_zero_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    // DUMP_D of D_MEM[4..5], loaded by row 3 through an address with nonzero upper bits
    oq.push_back(8'h5A);
    oq.push_back(8'hC3);
    o0 = n_out;
    send_byte(8'h04, 1'b0, 1'b0, 8'h00);
    send_byte(8'h04, 1'b0, 1'b0, 8'h00);
    send_byte(8'h00, 1'b0, 1'b0, 8'h00);
    send_byte(8'h02, 1'b0, 1'b0, 8'h00);
    send_byte(8'h00, 1'b0, 1'b0, 8'h00);
    k = 0;
    while ((oq.size() != 0 || busy !== 1'b0) && k < 60) begin
      out_ready = k[0];
      @(posedge clk);
      #1;
      k++;
    end
    out_ready = 1'b0;
    if (k >= 60) fail_now("dump_timeout");
    repeat (3) @(posedge clk);
    #1;
    check_output("dump_count", n_out - o0, 32'd2);
    check_output("dump_pending", oq.size(), 32'd0);
    check_output("dump_busy", {31'd0, busy}, 32'd0);

    // Unknown command sets the sticky error and stays idle
    send_byte(8'h7F, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check_output("badcmd_err", {31'd0, err}, 32'd1);
    check_output("badcmd_busy", {31'd0, busy}, 32'd0);
    check_output("badcmd_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Reset in the middle of a LOAD_D of 8 bytes
    d0 = n_dstb;
    send_byte(8'h02, 1'b0, 1'b0, 8'h00);
    send_byte(8'h20, 1'b0, 1'b0, 8'h00);
    send_byte(8'h00, 1'b0, 1'b0, 8'h00);
    send_byte(8'h08, 1'b0, 1'b0, 8'h00);
    send_byte(8'h00, 1'b0, 1'b0, 8'h00);
    send_byte(8'h91, 1'b1, 1'b1, 8'h20);
    send_byte(8'h92, 1'b1, 1'b1, 8'h21);
    send_byte(8'h93, 1'b1, 1'b1, 8'h22);
    @(posedge clk);
    #1;
    n_rst    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h94;
    @(posedge clk);
    #1;
    n_rst    = 1'b1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check_output("midrst_err", {31'd0, err}, 32'd0);
    check_output("midrst_busy", {31'd0, busy}, 32'd0);
    check_output("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("midrst_dmem_strobes", n_dstb - d0, 32'd3);
    check_output("midrst_pending", wq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
